dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 28 ++
 rtl/dmem_arbiter_rr_pick2.sv | 32 +++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - state_t     : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   - PORT_CPU/AUX: requester indices (0 = processor, 1 = auxiliary master)
//   - LAT_W       : width of the read-latency down-counter (RD_LAT 1..4)
//   - lat_load()  : counter preload for a given read latency
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int LAT_W = 2;

    // WAIT lasts rd_lat cycles; the counter counts down to zero, so it is
    // preloaded with rd_lat-1 and the zero cycle is the capture cycle.
    function automatic logic [LAT_W-1:0] lat_load(input int rd_lat);
        return LAT_W'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_rr_pick2
// Combinational two-way picker used by the arbiter in its IDLE state.
//   i_req0, i_req1 : pending requests
//   i_last_owner   : port granted most recently
//   o_any          : at least one request pending
//   o_sel          : chosen port (meaningful only when o_any is high)
// FIXED_PRIO = 1 : port 0 wins ties; 0 : the port that was not last served wins.
// -----------------------------------------------------------------------------
module dmem_arbiter_rr_pick2
    import dmem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_any,
    output logic o_sel
);

    always_comb begin
        o_any = i_req0 | i_req1;
        o_sel = PORT_CPU;
        if (i_req0 && i_req1) begin
            o_sel = (FIXED_PRIO != 0) ? PORT_CPU : ~i_last_owner;
        end else if (i_req1) begin
            o_sel = PORT_AUX;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port synchronous data memory between the processor
// (port 0) and an auxiliary master (port 1). One access is in flight at a time.
//
// Ports:
//   clock, reset           : system clock, asynchronous active-high reset
//   req0/1, we0/1          : level request and write flag per port
//   addr0/1, wdata0/1      : word address and write data per port
//   gnt0/1                 : one-cycle registered grant pulse
//   rvalid0/1, rdata0/1    : one-cycle read-valid pulse and held read data
//   address_dmem, data     : memory address / write data (registered)
//   wren                   : memory write enable, high only in ISSUE for writes
//   q_dmem                 : memory read data, valid RD_LAT cycles after ISSUE
//
// Timeline for a request sampled in IDLE cycle N:
//   N+1 ISSUE (gnt, wren for writes), write returns to IDLE at N+2,
//   read waits RD_LAT cycles and pulses rvalid at N+2+RD_LAT (state IDLE).
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    state_t             r_state;
    logic [1:0]         r_gnt;
    logic [1:0]         r_rvalid;
    logic [DATA_W-1:0]  r_rdata [2];
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_wren;
    logic               r_owner;
    logic               r_last_owner;
    logic [LAT_W-1:0]   r_cnt;

    logic               w_any;
    logic               w_sel;
    logic [ADDR_W-1:0]  w_addr [2];
    logic [DATA_W-1:0]  w_wdata [2];
    logic [1:0]         w_we;

    assign w_addr[0]  = addr0;
    assign w_addr[1]  = addr1;
    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;
    assign w_we       = {we1, we0};

    dmem_arbiter_rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_owner (r_last_owner),
        .o_any        (w_any),
        .o_sel        (w_sel)
    );

    // Single FSM; every output is a register so the memory and requesters
    // see glitch-free, edge-aligned signals.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_rdata[0]   <= '0;
            r_rdata[1]   <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_wren       <= 1'b0;
            r_owner      <= PORT_CPU;
            r_last_owner <= PORT_AUX;   // so port 0 wins the first tie
            r_cnt        <= '0;
        end else begin
            // Pulses default low; they are raised for exactly one cycle below.
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_wren   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt[w_sel] <= 1'b1;
                        r_addr       <= w_addr[w_sel];
                        r_data       <= w_wdata[w_sel];
                        r_wren       <= w_we[w_sel];
                        r_owner      <= w_sel;
                        r_last_owner <= w_sel;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // r_wren still holds the write flag of the access being issued.
                    if (r_wren) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= lat_load(RD_LAT);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // address_dmem is left untouched so the memory sees a stable address.
                    if (r_cnt == '0) begin
                        r_rdata[r_owner]  <= q_dmem;
                        r_rvalid[r_owner] <= 1'b1;
                        r_state           <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt0         = r_gnt[0];
    assign gnt1         = r_gnt[1];
    assign rvalid0      = r_rvalid[0];
    assign rvalid1      = r_rvalid[1];
    assign rdata0       = r_rdata[0];
    assign rdata1       = r_rdata[1];
    assign address_dmem = r_addr;
    assign data         = r_data;
    assign wren         = r_wren;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiter instances (round-robin and fixed priority), each with a simple
// RD_LAT=1 synchronous memory model preloaded with 32'hA5000000 | address.
// Directed stimulus pushes hand-computed grant/read-valid events (with the
// cycle they must appear in) into a per-instance queue; a negedge monitor pops
// and compares whenever an instance presents gnt or rvalid.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        bit          is_rv;
        int          port;
        int          cyc;
        logic [11:0] addr;
        logic        we;
        logic [31:0] d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- instance A: round-robin ----------------
    logic        a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
    logic [11:0] a_addr0 = 0, a_addr1 = 0;
    logic [31:0] a_wdata0 = 0, a_wdata1 = 0;
    logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_wren;
    logic [31:0] a_rd0, a_rd1, a_data, a_q;
    logic [11:0] a_adr;
    logic [31:0] mem_a [4096];

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset(reset),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rv0), .rvalid1(a_rv1),
        .rdata0(a_rd0), .rdata1(a_rd1),
        .address_dmem(a_adr), .data(a_data), .wren(a_wren), .q_dmem(a_q)
    );

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem_a[i] <= 32'hA500_0000 | 32'(i);
        end else if (a_wren) begin
            mem_a[a_adr] <= a_data;
        end
        a_q <= mem_a[a_adr];
    end

    // ---------------- instance B: fixed priority ----------------
    logic        b_req0 = 0, b_req1 = 0;
    logic [11:0] b_addr0 = 0, b_addr1 = 0;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_wren;
    logic [31:0] b_rd0, b_rd1, b_data, b_q;
    logic [11:0] b_adr;
    logic [31:0] mem_b [4096];

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset),
        .req0(b_req0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(32'h0), .wdata1(32'h0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rv0), .rvalid1(b_rv1),
        .rdata0(b_rd0), .rdata1(b_rd1),
        .address_dmem(b_adr), .data(b_data), .wren(b_wren), .q_dmem(b_q)
    );

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem_b[i] <= 32'hA500_0000 | 32'(i);
        end else if (b_wren) begin
            mem_b[b_adr] <= b_data;
        end
        b_q <= mem_b[b_adr];
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushe(input int idx, input bit is_rv, input int port, input int c,
                         input logic [11:0] addr, input logic we, input logic [31:0] d);
        exp_t e;
        e.is_rv = is_rv; e.port = port; e.cyc = c; e.addr = addr; e.we = we; e.d = d;
        if (idx == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic mon(input int idx, input logic g0, input logic g1, input logic rv0,
                       input logic rv1, input logic wr, input logic [11:0] ad,
                       input logic [31:0] dt, input logic [31:0] rd0, input logic [31:0] rd1);
        exp_t  e;
        bit    have;
        string tag;
        tag = (idx == 0) ? "A" : "B";
        if ((g0 && g1) || (rv0 && rv1)) chk({tag, "_two_ports_at_once"}, 1, 0);
        if (wr && !(g0 || g1)) chk({tag, "_wren_outside_issue"}, 1, 0);
        if (g0 || g1 || rv0 || rv1) begin
            have = (idx == 0) ? (qa.size() > 0) : (qb.size() > 0);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL %s_unexpected_event: got gnt=%b%b rvalid=%b%b expected none (cycle %0d)",
                         tag, g1, g0, rv1, rv0, cyc);
            end else begin
                e = (idx == 0) ? qa.pop_front() : qb.pop_front();
                chk({tag, "_event_kind"}, 64'(rv0 | rv1), 64'(e.is_rv));
                chk({tag, "_event_port"}, 64'(g1 | rv1), 64'(e.port));
                chk({tag, "_event_cycle"}, 64'(cyc), 64'(e.cyc));
                if (!e.is_rv) begin
                    chk({tag, "_gnt_address"}, 64'(ad), 64'(e.addr));
                    chk({tag, "_gnt_wren"}, 64'(wr), 64'(e.we));
                    if (e.we) chk({tag, "_gnt_wdata"}, 64'(dt), 64'(e.d));
                end else begin
                    chk({tag, "_rdata"}, 64'(rv1 ? rd1 : rd0), 64'(e.d));
                end
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, a_gnt0, a_gnt1, a_rv0, a_rv1, a_wren, a_adr, a_data, a_rd0, a_rd1);
        mon(1, b_gnt0, b_gnt1, b_rv0, b_rv1, b_wren, b_adr, b_data, b_rd0, b_rd1);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int k;
        tick(3);
        mem_init = 1'b0;
        reset    = 1'b0;
        tick(1);

        // Reset values
        chk("rst_gnt", {a_gnt1, a_gnt0}, 0);
        chk("rst_rvalid", {a_rv1, a_rv0}, 0);
        chk("rst_wren", a_wren, 0);
        chk("rst_address", a_adr, 0);
        chk("rst_data", a_data, 0);
        chk("rst_rdata", {a_rd1, a_rd0}, 0);

        // Single write from port 0, then read it back through port 1
        k = cyc;
        a_req0 = 1; a_we0 = 1; a_addr0 = 12'h010; a_wdata0 = 32'hDEADBEEF;
        pushe(0, 0, 0, k + 1, 12'h010, 1, 32'hDEADBEEF);
        tick(1); a_req0 = 0; a_we0 = 0;
        tick(1);
        a_req1 = 1; a_we1 = 0; a_addr1 = 12'h010;
        pushe(0, 0, 1, k + 3, 12'h010, 0, 0);
        pushe(0, 1, 1, k + 5, 0, 0, 32'hDEADBEEF);
        tick(1); a_req1 = 0;
        tick(3);

        // Both ports read continuously: grants alternate 0,1,0,1
        k = cyc;
        a_req0 = 1; a_we0 = 0; a_addr0 = 12'h020;
        a_req1 = 1; a_we1 = 0; a_addr1 = 12'h030;
        pushe(0, 0, 0, k + 1,  12'h020, 0, 0);
        pushe(0, 1, 0, k + 3,  0, 0, 32'hA5000020);
        pushe(0, 0, 1, k + 4,  12'h030, 0, 0);
        pushe(0, 1, 1, k + 6,  0, 0, 32'hA5000030);
        pushe(0, 0, 0, k + 7,  12'h020, 0, 0);
        pushe(0, 1, 0, k + 9,  0, 0, 32'hA5000020);
        pushe(0, 0, 1, k + 10, 12'h030, 0, 0);
        pushe(0, 1, 1, k + 12, 0, 0, 32'hA5000030);
        tick(10); a_req0 = 0; a_req1 = 0;
        tick(4);

        // Port 1 write request withdrawn inside port 0's WAIT cycle
        k = cyc;
        a_req0 = 1; a_we0 = 0; a_addr0 = 12'h040;
        pushe(0, 0, 0, k + 1, 12'h040, 0, 0);
        pushe(0, 1, 0, k + 3, 0, 0, 32'hA5000040);
        tick(1); a_req0 = 0;
        tick(1);
        a_req1 = 1; a_we1 = 1; a_addr1 = 12'h050; a_wdata1 = 32'h12345678;
        @(negedge clock); #1;
        a_req1 = 0; a_we1 = 0;
        tick(2);
        k = cyc;
        a_req0 = 1; a_addr0 = 12'h050;   // must still hold the preload pattern
        pushe(0, 0, 0, k + 1, 12'h050, 0, 0);
        pushe(0, 1, 0, k + 3, 0, 0, 32'hA5000050);
        tick(1); a_req0 = 0;
        tick(3);
        chk("rdata1_held", a_rd1, 32'hA5000030);

        // Reset asserted during a port-0 read WAIT
        k = cyc;
        a_req0 = 1; a_addr0 = 12'h060;
        pushe(0, 0, 0, k + 1, 12'h060, 0, 0);
        tick(1); a_req0 = 0;
        tick(1);
        #2 reset = 1;
        #1;
        chk("async_rst_gnt", {a_gnt1, a_gnt0}, 0);
        chk("async_rst_rvalid", {a_rv1, a_rv0}, 0);
        chk("async_rst_wren", a_wren, 0);
        chk("async_rst_address", a_adr, 0);
        chk("async_rst_rdata0", a_rd0, 0);
        tick(1); reset = 0;
        tick(4);
        k = cyc;
        a_req0 = 1; a_addr0 = 12'h070;
        a_req1 = 1; a_addr1 = 12'h080;
        pushe(0, 0, 0, k + 1, 12'h070, 0, 0);
        pushe(0, 1, 0, k + 3, 0, 0, 32'hA5000070);
        pushe(0, 0, 1, k + 4, 12'h080, 0, 0);
        pushe(0, 1, 1, k + 6, 0, 0, 32'hA5000080);
        tick(4); a_req0 = 0; a_req1 = 0;
        tick(4);

        // Fixed priority: port 0 keeps winning until it drops its request
        k = cyc;
        b_req0 = 1; b_addr0 = 12'h100;
        b_req1 = 1; b_addr1 = 12'h200;
        pushe(1, 0, 0, k + 1,  12'h100, 0, 0);
        pushe(1, 1, 0, k + 3,  0, 0, 32'hA5000100);
        pushe(1, 0, 0, k + 4,  12'h100, 0, 0);
        pushe(1, 1, 0, k + 6,  0, 0, 32'hA5000100);
        pushe(1, 0, 0, k + 7,  12'h100, 0, 0);
        pushe(1, 1, 0, k + 9,  0, 0, 32'hA5000100);
        pushe(1, 0, 1, k + 10, 12'h200, 0, 0);
        pushe(1, 1, 1, k + 12, 0, 0, 32'hA5000200);
        tick(7); b_req0 = 0;
        tick(3); b_req1 = 0;
        tick(4);

        chk("A_events_outstanding", 64'(qa.size()), 0);
        chk("B_events_outstanding", 64'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected stimulus completion");
        $fatal(1, "timeout");
    end

endmodule
